alu_core: RTL and testbench

ALU_CORE -- requirements
Module: alu_core

---
 rtl/alu_core_if.sv | 26 ++
 rtl/alu_core.sv | 103 ++++++++++
 tb/tb_alu_core.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/alu_core_if.sv
// alu_core_if: operand/opcode/result bundle between an ALU user and alu_core.
// The master drives operands and opcode and observes the registered results;
// the slave (alu_core) does the opposite.
interface alu_core_if #(
  parameter int WIDTH = 20
);

  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic [2:0]       op_select;
  logic             be_select;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             e;

  modport master (
    output i0, i1, op_select, be_select,
    input  s, cout, e
  );

  modport slave (
    input  i0, i1, op_select, be_select,
    output s, cout, e
  );

endinterface

// File: rtl/alu_core.sv
// alu_core: single-cycle registered ALU (ADD, SUB, AND, OR, XOR, optional shifts)
// with an equal / not-equal compare flag.
// Build option: define ALU_SHIFT_EN to enable ops 101 SHL, 110 SHR, 111 ASR
// (shift amount is i1[4:0]). Without it those opcodes yield s = 0, cout = 0.
module alu_core #(
  parameter int WIDTH = 20
) (
  input  logic          clk,
  input  logic          rst,
  alu_core_if.slave     bus
);

  logic [WIDTH-1:0] res_s;
  logic             res_cout;
  logic             res_e;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;

`ifdef ALU_SHIFT_EN
  logic [4:0]       amt;
  logic             amt_big;
  logic [WIDTH:0]   shl_ext;
  logic [WIDTH:0]   shr_ext;
  logic [WIDTH:0]   asr_ext;
`endif

  // Combinational datapath: every operation computed from the current inputs, opcode picks one
  always_comb begin
    res_s    = '0;
    res_cout = 1'b0;
    sum_ext  = {1'b0, bus.i0} + {1'b0, bus.i1};
    diff_ext = {1'b0, bus.i0} - {1'b0, bus.i1};
    res_e    = bus.be_select ? (bus.i0 == bus.i1) : (bus.i0 != bus.i1);
`ifdef ALU_SHIFT_EN
    // One extra guard bit catches the last bit shifted out in each direction
    amt      = bus.i1[4:0];
    amt_big  = (int'(amt) >= WIDTH);
    shl_ext  = {1'b0, bus.i0} << amt;
    shr_ext  = {bus.i0, 1'b0} >> amt;
    asr_ext  = $signed({bus.i0, 1'b0}) >>> amt;
`endif
    case (bus.op_select)
      3'b000: begin
        res_s    = sum_ext[WIDTH-1:0];
        res_cout = sum_ext[WIDTH];
      end
      3'b001: begin
        res_s    = diff_ext[WIDTH-1:0];
        res_cout = diff_ext[WIDTH];
      end
      3'b010: res_s = bus.i0 & bus.i1;
      3'b011: res_s = bus.i0 | bus.i1;
      3'b100: res_s = bus.i0 ^ bus.i1;
`ifdef ALU_SHIFT_EN
      3'b101: begin
        if (amt_big) begin
          res_s    = '0;
          res_cout = 1'b0;
        end else begin
          res_s    = shl_ext[WIDTH-1:0];
          res_cout = shl_ext[WIDTH];
        end
      end
      3'b110: begin
        if (amt_big) begin
          res_s    = '0;
          res_cout = 1'b0;
        end else begin
          res_s    = shr_ext[WIDTH:1];
          res_cout = shr_ext[0];
        end
      end
      3'b111: begin
        if (amt_big) begin
          res_s    = {WIDTH{bus.i0[WIDTH-1]}};
          res_cout = 1'b0;
        end else begin
          res_s    = asr_ext[WIDTH:1];
          res_cout = asr_ext[0];
        end
      end
`endif
      default: begin
        res_s    = '0;
        res_cout = 1'b0;
      end
    endcase
  end

  // Output registers: reset wins over the result computed for the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.s    <= '0;
      bus.cout <= 1'b0;
      bus.e    <= 1'b0;
    end else begin
      bus.s    <= res_s;
      bus.cout <= res_cout;
      bus.e    <= res_e;
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed vectors followed by random vectors for alu_core,
// compared against an arithmetic reference model. Honours ALU_SHIFT_EN.
module tb_alu_core;

  localparam int    W   = 20;
  localparam longint MOD = longint'(1) << W;

  logic clk;
  logic rst;
  int   compare_count;
  int   fail_count;

  alu_core_if #(.WIDTH(W)) bus ();

  alu_core #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic longint pow2(input int n);
    longint p = 1;
    for (int k = 0; k < n; k++) p = p * 2;
    return p;
  endfunction

  function automatic longint floor_div(input longint v, input longint d);
    longint q = v / d;
    if ((v % d != 0) && (v < 0)) q = q - 1;
    return q;
  endfunction

  // Reference model: results from plain integer arithmetic on unsigned values
  function automatic void ref_model(input int op, input longint a, input longint b,
                                    input bit be, output longint s, output bit c,
                                    output bit eq);
    int     amt;
    longint sv;
    eq  = be ? (a == b) : (a != b);
    s   = 0;
    c   = 1'b0;
    amt = int'(b % 32);
    case (op)
      0: begin s = (a + b) % MOD; c = (a + b) >= MOD; end
      1: begin s = (a - b + MOD) % MOD; c = a < b; end
      2: s = a & b;
      3: s = a | b;
      4: s = a ^ b;
`ifdef ALU_SHIFT_EN
      5: begin
        if (amt == 0) s = a;
        else if (amt < W) begin
          s = (a * pow2(amt)) % MOD;
          c = ((a / pow2(W - amt)) % 2) == 1;
        end
      end
      6: begin
        if (amt == 0) s = a;
        else if (amt < W) begin
          s = a / pow2(amt);
          c = ((a / pow2(amt - 1)) % 2) == 1;
        end
      end
      7: begin
        sv = (a >= MOD / 2) ? a - MOD : a;
        if (amt == 0) s = a;
        else if (amt < W) begin
          s = (floor_div(sv, pow2(amt)) + MOD) % MOD;
          c = ((a / pow2(amt - 1)) % 2) == 1;
        end else s = (sv < 0) ? MOD - 1 : 0;
      end
`endif
      default: begin s = 0; c = 1'b0; end
    endcase
  endfunction

  task automatic apply_stimulus(input bit r, input int op, input longint a,
                                input longint b, input bit be);
    rst           = r;
    bus.op_select = op[2:0];
    bus.i0        = a[W-1:0];
    bus.i1        = b[W-1:0];
    bus.be_select = be;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input longint exp_s,
                              input bit exp_c, input bit exp_e);
    logic [W-1:0] es;
    es = exp_s[W-1:0];
    compare_count++;
    assert (bus.s === es) else begin
      fail_count++;
      $error("[TB] FAIL %s s: observed %h required %h", tag, bus.s, es);
    end
    compare_count++;
    assert (bus.cout === exp_c) else begin
      fail_count++;
      $error("[TB] FAIL %s cout: observed %b required %b", tag, bus.cout, exp_c);
    end
    compare_count++;
    assert (bus.e === exp_e) else begin
      fail_count++;
      $error("[TB] FAIL %s e: observed %b required %b", tag, bus.e, exp_e);
    end
  endtask

  // Directed steps, then random vectors against the model, then summary
  initial begin
    longint a, b, es;
    int     op, mode;
    bit     be, ec, ee;
    compare_count = 0;
    fail_count    = 0;
    rst           = 1'b1;
    bus.i0        = '0;
    bus.i1        = '0;
    bus.op_select = 3'b000;
    bus.be_select = 1'b0;

    apply_stimulus(1, 0, 10, 10, 1);            check_output("reset",      0, 0, 0);
    apply_stimulus(0, 0, 10, 10, 1);            check_output("add_10_10",  20, 0, 1);
    apply_stimulus(0, 0, 'hFFFFF, 1, 0);        check_output("add_carry",  0, 1, 1);
    apply_stimulus(0, 1, 100, 150, 0);          check_output("sub_borrow", 'hFFFCE, 1, 1);
    apply_stimulus(0, 1, 10, 10, 1);            check_output("sub_zero",   0, 0, 1);
    apply_stimulus(0, 2, 'hFFFFF, 'hFFFFF, 1);  check_output("and_ones",   'hFFFFF, 0, 1);
    apply_stimulus(0, 3, 0, 10, 1);             check_output("or_basic",   10, 0, 0);
    apply_stimulus(0, 4, 'hA0B0C, 'h0D0E0, 1);  check_output("xor_basic",  'hADBEC, 0, 0);
    apply_stimulus(1, 0, 10, 11, 1);            check_output("rst_mid",    0, 0, 0);
    apply_stimulus(0, 0, 10, 11, 0);            check_output("after_rst",  21, 0, 1);
`ifdef ALU_SHIFT_EN
    apply_stimulus(0, 7, 'h80000, 4, 0);        check_output("asr_4",      'hF8000, 0, 1);
    apply_stimulus(0, 5, 'h80001, 1, 0);        check_output("shl_out",    'h00002, 1, 1);
    apply_stimulus(0, 6, 'h00003, 1, 0);        check_output("shr_out",    'h00001, 1, 1);
    apply_stimulus(0, 5, 'h12345, 0, 0);        check_output("shl_amt0",   'h12345, 0, 1);
    apply_stimulus(0, 5, 'h12345, 20, 0);       check_output("shl_big",    0, 0, 1);
    apply_stimulus(0, 7, 'h80000, 25, 0);       check_output("asr_big",    'hFFFFF, 0, 1);
`else
    apply_stimulus(0, 5, 'h12345, 3, 1);        check_output("op101_off",  0, 0, 0);
    apply_stimulus(0, 7, 'h55555, 'h55555, 1);  check_output("op111_off",  0, 0, 1);
`endif

    for (int n = 0; n < 300; n++) begin
      op   = int'($urandom_range(0, 7));
      be   = 1'($urandom_range(0, 1));
      a    = longint'($urandom_range(0, 32'(MOD - 1)));
      mode = int'($urandom_range(0, 3));
      if (mode == 0)      b = a;
      else if (mode == 1) b = longint'($urandom_range(0, 40));
      else                b = longint'($urandom_range(0, 32'(MOD - 1)));
      ref_model(op, a, b, be, es, ec, ee);
      apply_stimulus(0, op, a, b, be);
      check_output($sformatf("rand%0d_op%0d", n, op), es, ec, ee);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
